// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: serialises one word per handshake into a start/data/parity/stop frame,
// paced by the shared baud timer's oversampling tick, which it gates through baud_en.
module uart_tx_ctrl #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic [DBIT-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic            parity_en,
  input  logic            parity_odd,
  output logic            tx,
  output logic            tx_done,
  output logic            busy,
  output logic            baud_en
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [5:0] OS_LAST  = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] SB_LAST  = 6'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST = 3'(DBIT - 1);

  state_t          state_q, state_d;
  logic [5:0]      tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            par_en_q, par_en_d;
  logic            par_bit_q, par_bit_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  function automatic logic calc_parity(input logic [DBIT-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d   = tx_data;
          par_en_d  = parity_en;
          par_bit_d = calc_parity(tx_data, parity_odd);
          tick_d    = '0;
          state_d   = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              state_d = par_en_q ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == SB_LAST) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line changes on the same edge as the FSM
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign baud_en  = busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: default build plus a DBIT=7/OVERSAMPLE=8/SB_TICK=32 build,
// driven by a gated tick generator (one tick per 4 clocks while enabled).
module tb_uart_tx_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, s_tick;
  logic [7:0] tx_data;
  logic       tx_valid, parity_en, parity_odd;
  logic       tx_ready, tx, tx_done, busy, baud_en;
  logic [6:0] tx_data7;
  logic       tx_valid7, pe7, po7;
  logic       tx_ready7, tx7, tx_done7, busy7, baud_en7;

  int   checks = 0;
  int   errors = 0;
  logic tick_free = 1'b0;
  int   tcnt = 0;

  uart_tx_ctrl dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .parity_en(parity_en), .parity_odd(parity_odd), .tx(tx),
    .tx_done(tx_done), .busy(busy), .baud_en(baud_en)
  );

  uart_tx_ctrl #(.DBIT(7), .OVERSAMPLE(8), .SB_TICK(32)) dut7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_data(tx_data7), .tx_valid(tx_valid7),
    .tx_ready(tx_ready7), .parity_en(pe7), .parity_odd(po7), .tx(tx7),
    .tx_done(tx_done7), .busy(busy7), .baud_en(baud_en7)
  );

  // Baud timer model: restarts whenever disabled, so the first tick comes 4 clocks after enable
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_free || baud_en || baud_en7) begin
        s_tick = (tcnt == 3);
        tcnt   = (tcnt + 1) % 4;
      end else begin
        s_tick = 1'b0;
        tcnt   = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input bit sel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if ((sel ? tx_ready7 : tx_ready) === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout observed 0 expected 1");
    end
  endtask

  // Entered just after the accepting edge; samples each bit mid-period and the tx_done window.
  task automatic run_frame(input bit sel, input logic [15:0] bits, input int nb, input int bclk,
                           input int stopclk, input logic [7:0] mid, input string tag);
    int cur, tgt, total;
    @(negedge clk);
    cur = 1;
    chk($sformatf("%s_tx_fall", tag), sel ? tx7 : tx, 1'b0);
    chk($sformatf("%s_busy", tag), sel ? busy7 : busy, 1'b1);
    chk($sformatf("%s_baud_en", tag), sel ? baud_en7 : baud_en, 1'b1);
    chk($sformatf("%s_not_ready", tag), sel ? tx_ready7 : tx_ready, 1'b0);
    for (int k = 0; k < nb; k++) begin
      tgt = k * bclk + bclk / 2;
      repeat (tgt - cur) @(negedge clk);
      cur = tgt;
      chk($sformatf("%s_bit%0d", tag, k), sel ? tx7 : tx, bits[k]);
      if (k == 3) begin
        if (sel) tx_data7 = mid[6:0];
        else begin
          tx_data    = mid;
          parity_odd = ~parity_odd;
        end
      end
    end
    total = nb * bclk + stopclk;
    tgt = nb * bclk + stopclk / 2;
    repeat (tgt - cur) @(negedge clk);
    cur = tgt;
    chk($sformatf("%s_stop", tag), sel ? tx7 : tx, 1'b1);
    repeat (total - cur) @(negedge clk);
    cur = total;
    chk($sformatf("%s_done_early", tag), sel ? tx_done7 : tx_done, 1'b0);
    chk($sformatf("%s_ready_early", tag), sel ? tx_ready7 : tx_ready, 1'b0);
    @(negedge clk);
    chk($sformatf("%s_done", tag), sel ? tx_done7 : tx_done, 1'b1);
    chk($sformatf("%s_ready_at_done", tag), sel ? tx_ready7 : tx_ready, 1'b1);
    chk($sformatf("%s_idle_tx", tag), sel ? tx7 : tx, 1'b1);
  endtask

  initial begin
    int bad;
    reset = 1'b0; tx_valid = 1'b0; tx_data = '0; parity_en = 1'b0; parity_odd = 1'b0;
    tx_valid7 = 1'b0; tx_data7 = '0; pe7 = 1'b0; po7 = 1'b0; tick_free = 1'b1;

    // Reset held with random inputs
    repeat (6) begin
      @(negedge clk);
      tx_valid  = 1'($urandom);
      tx_data   = 8'($urandom);
      parity_en = 1'($urandom);
      tx_valid7 = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_baud_en", baud_en, 1'b0);
    chk("rst_tx7", tx7, 1'b1);

    // Release and tick 50 times with no valid
    tx_valid = 1'b0; tx_valid7 = 1'b0; parity_en = 1'b0; reset = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("idle_ticks_line", 16'(bad), 16'd0);
    chk("idle_ready", tx_ready, 1'b1);
    tick_free = 1'b0;

    // 0x55, no parity
    tx_data = 8'h55; parity_en = 1'b0; parity_odd = 1'b0; tx_valid = 1'b1;
    wait_ready(0); @(posedge clk); #1 tx_valid = 1'b0;
    run_frame(0, 16'h00AA, 9, 64, 64, 8'hAA, "f55");

    // 0x07 even parity -> parity bit 1
    tx_data = 8'h07; parity_en = 1'b1; parity_odd = 1'b0; tx_valid = 1'b1;
    wait_ready(0); @(posedge clk); #1 tx_valid = 1'b0;
    run_frame(0, 16'h020E, 10, 64, 64, 8'hF8, "par_even");

    // 0x07 odd parity -> parity bit 0
    tx_data = 8'h07; parity_en = 1'b1; parity_odd = 1'b1; tx_valid = 1'b1;
    wait_ready(0); @(posedge clk); #1 tx_valid = 1'b0;
    run_frame(0, 16'h000E, 10, 64, 64, 8'hF8, "par_odd");

    // Back-to-back: 0xA3 then 0x3C with valid held; data switches to 0x3C mid-frame
    tx_data = 8'hA3; parity_en = 1'b0; parity_odd = 1'b0; tx_valid = 1'b1;
    wait_ready(0); @(posedge clk);
    run_frame(0, 16'h0146, 9, 64, 64, 8'h3C, "b2b_a3");
    @(posedge clk); #1 tx_valid = 1'b0;
    run_frame(0, 16'h0078, 9, 64, 64, 8'h00, "b2b_3c");

    // Reset during data bit 3 of 0x00
    tx_data = 8'h00; parity_en = 1'b0; tx_valid = 1'b1;
    wait_ready(0); @(posedge clk); #1 tx_valid = 1'b0;
    repeat (288) @(negedge clk);
    chk("midrst_pre_tx", tx, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", tx_ready, 1'b1);
    @(negedge clk); reset = 1'b1;

    tx_data = 8'hF0; parity_en = 1'b0; tx_valid = 1'b1;
    wait_ready(0); @(posedge clk); #1 tx_valid = 1'b0;
    run_frame(0, 16'h01E0, 9, 64, 64, 8'h0F, "post_rst_f0");

    // DBIT=7, OVERSAMPLE=8, SB_TICK=32 build: 96-tick frame
    tx_data7 = 7'h5A; tx_valid7 = 1'b1;
    wait_ready(1); @(posedge clk); #1 tx_valid7 = 1'b0;
    run_frame(1, 16'h00B4, 8, 32, 128, 8'h25, "d7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
